// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: write port, two read addresses, clear request,
// registered read data and the sweep-busy flag.
interface reg_file_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] IN;
  logic [AW-1:0]    INADDRESS;
  logic             WRITE;
  logic [AW-1:0]    OUT1ADDRESS;
  logic [AW-1:0]    OUT2ADDRESS;
  logic             CLEAR;
  logic [WIDTH-1:0] OUT1;
  logic [WIDTH-1:0] OUT2;
  logic             BUSY;

  modport master (
    output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
    input  OUT1, OUT2, BUSY
  );

  modport slave (
    input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
    output OUT1, OUT2, BUSY
  );
endinterface

// File: rtl/reg_file_param.sv
// Parameterised register file: one write port, two registered read ports with
// write-through bypass, optional hard-wired zero register, and a sweeping clear.
module reg_file_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  reg_file_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [WIDTH-1:0] out2_q, out2_d;
  logic             wr_en;
  logic [WIDTH-1:0] rd1, rd2;

  // Address 0 is masked on read as well, so a zero register stays zero even
  // though the entry itself is never written.
  always_comb begin
    rd1 = mem_q[bus.OUT1ADDRESS];
    rd2 = mem_q[bus.OUT2ADDRESS];
    if (ZERO_REG != 0 && bus.OUT1ADDRESS == '0) rd1 = '0;
    if (ZERO_REG != 0 && bus.OUT2ADDRESS == '0) rd2 = '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        wr_en = bus.WRITE && !bus.CLEAR &&
                !(ZERO_REG != 0 && bus.INADDRESS == '0);
        if (wr_en) mem_d[bus.INADDRESS] = bus.IN;
        out1_d = (wr_en && bus.INADDRESS == bus.OUT1ADDRESS) ? bus.IN : rd1;
        out2_d = (wr_en && bus.INADDRESS == bus.OUT2ADDRESS) ? bus.IN : rd2;
        if (bus.CLEAR) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        mem_d[cnt_q] = '0;
        out1_d       = '0;
        out2_d       = '0;
        cnt_d        = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.OUT1 = out1_q;
  assign bus.OUT2 = out2_q;
  assign bus.BUSY = (state_q == SWEEP);

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: one plain instance and one with ZERO_REG=1.
module tb_reg_file_param;
  logic CLK;
  logic RESET;
  int   errors = 0;
  int   checks = 0;

  reg_file_param_if #(.WIDTH(8), .DEPTH(8)) bus_a ();
  reg_file_param_if #(.WIDTH(8), .DEPTH(8)) bus_z ();

  reg_file_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0)) u_a (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_a)
  );

  reg_file_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1)) u_z (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_z)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    bus_a.IN = '0; bus_a.INADDRESS = '0; bus_a.WRITE = 1'b0;
    bus_a.OUT1ADDRESS = '0; bus_a.OUT2ADDRESS = '0; bus_a.CLEAR = 1'b0;
    bus_z.IN = '0; bus_z.INADDRESS = '0; bus_z.WRITE = 1'b0;
    bus_z.OUT1ADDRESS = '0; bus_z.OUT2ADDRESS = '0; bus_z.CLEAR = 1'b0;

    // Asynchronous reset, before any clock edge
    #1 RESET = 1'b0;
    #1;
    chk("rst_out1", bus_a.OUT1, 8'h00);
    chk("rst_out2", bus_a.OUT2, 8'h00);
    chk("rst_busy", {7'b0, bus_a.BUSY}, 8'h00);
    chk("rst_z_out1", bus_z.OUT1, 8'h00);

    // WRITE/CLEAR ignored while held in reset
    bus_a.WRITE = 1'b1; bus_a.INADDRESS = 3'd3; bus_a.IN = 8'hEE;
    bus_a.CLEAR = 1'b1; bus_a.OUT1ADDRESS = 3'd3;
    step; step;
    chk("inrst_out1", bus_a.OUT1, 8'h00);
    chk("inrst_busy", {7'b0, bus_a.BUSY}, 8'h00);
    bus_a.WRITE = 1'b0; bus_a.CLEAR = 1'b0;
    RESET = 1'b1;
    step;
    chk("post_rst_addr3", bus_a.OUT1, 8'h00);
    chk("post_rst_busy", {7'b0, bus_a.BUSY}, 8'h00);

    // Write 0xA5 to addr 3, then read it back
    bus_a.WRITE = 1'b1; bus_a.INADDRESS = 3'd3; bus_a.IN = 8'hA5;
    bus_a.OUT1ADDRESS = 3'd0; bus_a.OUT2ADDRESS = 3'd0;
    step;
    chk("wr_read_other", bus_a.OUT1, 8'h00);
    bus_a.WRITE = 1'b0; bus_a.OUT1ADDRESS = 3'd3;
    step;
    chk("read_a5", bus_a.OUT1, 8'hA5);

    // Bypass on both ports
    bus_a.WRITE = 1'b1; bus_a.INADDRESS = 3'd5; bus_a.IN = 8'h3C;
    bus_a.OUT1ADDRESS = 3'd5; bus_a.OUT2ADDRESS = 3'd5;
    step;
    chk("byp_out1", bus_a.OUT1, 8'h3C);
    chk("byp_out2", bus_a.OUT2, 8'h3C);
    bus_a.WRITE = 1'b0;
    step;
    chk("byp_stored", bus_a.OUT1, 8'h3C);

    bus_a.OUT1ADDRESS = 3'd3; bus_a.OUT2ADDRESS = 3'd3;
    step;
    chk("same_addr_out1", bus_a.OUT1, 8'hA5);
    chk("same_addr_out2", bus_a.OUT2, 8'hA5);

    bus_a.WRITE = 1'b1; bus_a.INADDRESS = 3'd6; bus_a.IN = 8'h42;
    bus_a.OUT1ADDRESS = 3'd6; bus_a.OUT2ADDRESS = 3'd5;
    step;
    chk("mixed_out1", bus_a.OUT1, 8'h42);
    chk("mixed_out2", bus_a.OUT2, 8'h3C);

    // Fill with 0xFF then clear
    for (int i = 0; i < 8; i++) begin
      bus_a.WRITE = 1'b1; bus_a.INADDRESS = 3'(i); bus_a.IN = 8'hFF;
      step;
    end
    bus_a.WRITE = 1'b0; bus_a.OUT1ADDRESS = 3'd7;
    step;
    chk("fill_ff", bus_a.OUT1, 8'hFF);

    bus_a.CLEAR = 1'b1;
    step;
    chk("busy_c0", {7'b0, bus_a.BUSY}, 8'h01);
    bus_a.CLEAR = 1'b0;
    bus_a.WRITE = 1'b1; bus_a.INADDRESS = 3'd1; bus_a.IN = 8'h11;
    bus_a.OUT1ADDRESS = 3'd1; bus_a.OUT2ADDRESS = 3'd1;
    for (int i = 1; i < 8; i++) begin
      bus_a.CLEAR = (i == 3);
      step;
      chk($sformatf("busy_c%0d", i), {7'b0, bus_a.BUSY}, 8'h01);
      chk($sformatf("sweep_out1_c%0d", i), bus_a.OUT1, 8'h00);
    end
    bus_a.CLEAR = 1'b0; bus_a.WRITE = 1'b0;
    step;
    chk("busy_end", {7'b0, bus_a.BUSY}, 8'h00);
    chk("sweep_out2_end", bus_a.OUT2, 8'h00);

    for (int a = 0; a < 8; a++) begin
      bus_a.OUT1ADDRESS = 3'(a); bus_a.OUT2ADDRESS = 3'(7 - a);
      step;
      chk($sformatf("clr_rd1_%0d", a), bus_a.OUT1, 8'h00);
      chk($sformatf("clr_rd2_%0d", a), bus_a.OUT2, 8'h00);
    end

    // CLEAR and WRITE in the same cycle: write dropped, no bypass
    bus_a.WRITE = 1'b1; bus_a.INADDRESS = 3'd2; bus_a.IN = 8'h55;
    step;
    bus_a.CLEAR = 1'b1; bus_a.IN = 8'h77; bus_a.OUT1ADDRESS = 3'd2;
    step;
    chk("coll_stale", bus_a.OUT1, 8'h55);
    chk("coll_busy", {7'b0, bus_a.BUSY}, 8'h01);
    bus_a.CLEAR = 1'b0; bus_a.WRITE = 1'b0;
    repeat (8) step;
    chk("coll_busy_end", {7'b0, bus_a.BUSY}, 8'h00);

    // First IDLE cycle after the sweep accepts a write
    bus_a.WRITE = 1'b1; bus_a.INADDRESS = 3'd4; bus_a.IN = 8'h99;
    bus_a.OUT1ADDRESS = 3'd2; bus_a.OUT2ADDRESS = 3'd4;
    step;
    chk("coll_addr2", bus_a.OUT1, 8'h00);
    chk("first_idle_wr", bus_a.OUT2, 8'h99);

    // Reset at sweep cycle 3
    bus_a.INADDRESS = 3'd7; bus_a.IN = 8'hAB;
    step;
    bus_a.WRITE = 1'b0; bus_a.CLEAR = 1'b1;
    step;
    bus_a.CLEAR = 1'b0;
    step; step; step;
    chk("mid_busy", {7'b0, bus_a.BUSY}, 8'h01);
    #2 RESET = 1'b0;
    #1;
    chk("async_busy", {7'b0, bus_a.BUSY}, 8'h00);
    chk("async_out1", bus_a.OUT1, 8'h00);
    chk("async_out2", bus_a.OUT2, 8'h00);
    step;
    RESET = 1'b1;
    bus_a.WRITE = 1'b1; bus_a.INADDRESS = 3'd3; bus_a.IN = 8'h5A;
    bus_a.OUT1ADDRESS = 3'd3; bus_a.OUT2ADDRESS = 3'd4;
    step;
    chk("rel_first_wr", bus_a.OUT1, 8'h5A);
    chk("rel_addr4", bus_a.OUT2, 8'h00);
    bus_a.WRITE = 1'b0; bus_a.OUT1ADDRESS = 3'd7; bus_a.OUT2ADDRESS = 3'd6;
    step;
    chk("rel_addr7", bus_a.OUT1, 8'h00);
    chk("rel_addr6", bus_a.OUT2, 8'h00);
    chk("rel_busy", {7'b0, bus_a.BUSY}, 8'h00);

    // ZERO_REG: address 0 ignores writes and bypass; plain instance does not
    bus_z.WRITE = 1'b1; bus_z.INADDRESS = 3'd0; bus_z.IN = 8'h9E;
    bus_z.OUT1ADDRESS = 3'd0; bus_z.OUT2ADDRESS = 3'd0;
    bus_a.WRITE = 1'b1; bus_a.INADDRESS = 3'd0; bus_a.IN = 8'h9E;
    bus_a.OUT1ADDRESS = 3'd0;
    step;
    chk("z_byp0_out1", bus_z.OUT1, 8'h00);
    chk("z_byp0_out2", bus_z.OUT2, 8'h00);
    chk("a_byp0_out1", bus_a.OUT1, 8'h9E);
    bus_a.WRITE = 1'b0;
    bus_z.INADDRESS = 3'd1; bus_z.IN = 8'h12; bus_z.OUT2ADDRESS = 3'd1;
    step;
    chk("z_rd0", bus_z.OUT1, 8'h00);
    chk("z_byp1", bus_z.OUT2, 8'h12);
    bus_z.WRITE = 1'b0; bus_z.OUT2ADDRESS = 3'd0;
    step;
    chk("z_later_out1", bus_z.OUT1, 8'h00);
    chk("z_later_out2", bus_z.OUT2, 8'h00);
    chk("a_addr0_kept", bus_a.OUT1, 8'h9E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter WIDTH, default 8: data width of every register and data port, in bits.
REQ-002 Parameter DEPTH, default 8: register count; power of two, at least 2.
REQ-003 Parameter ZERO_REG, default 0: when 1, register 0 reads as 0 and ignores writes.
REQ-004 Derived constant AW = log2(DEPTH); address width.
REQ-005 CLK input 1: single clock; all state changes on the rising edge.
REQ-006 RESET input 1: asynchronous, active-low reset.
REQ-007 IN input WIDTH: write data.
REQ-008 INADDRESS input AW: write address.
REQ-009 WRITE input 1: write enable.
REQ-010 OUT1ADDRESS input AW: read port 1 address.
REQ-011 OUT2ADDRESS input AW: read port 2 address.
REQ-012 CLEAR input 1: request to zero the whole file; single-cycle pulse.
REQ-013 OUT1 output WIDTH: registered read data, port 1.
REQ-014 OUT2 output WIDTH: registered read data, port 2.
REQ-015 BUSY output 1: high while a clear sweep is in progress.

Function
REQ-016 The FSM SHALL have two states, IDLE and SWEEP; BUSY SHALL equal (state == SWEEP) with no further decode.
REQ-017 In IDLE, with WRITE=1 and CLEAR=0, the file SHALL store IN at INADDRESS on the rising edge, except INADDRESS 0 when ZERO_REG=1.
REQ-018 In IDLE, on each rising edge, OUT1/OUT2 SHALL load the contents of OUT1ADDRESS/OUT2ADDRESS, giving a read latency of 1 cycle.
REQ-019 Write-through bypass: if a write occurs in the same cycle and INADDRESS equals a read address, that port SHALL load IN, not the stale contents.
REQ-020 Bypass SHALL NOT apply to address 0 when ZERO_REG=1; that port SHALL load 0.
REQ-021 Both read ports SHALL be able to read the same address in the same cycle, each returning identical data.
REQ-022 In IDLE, CLEAR=1 SHALL move the FSM to SWEEP and load the sweep counter with 0; a WRITE in that same cycle SHALL be dropped.
REQ-023 In SWEEP, each rising edge SHALL zero register[counter] and increment the counter; after zeroing entry DEPTH-1, the FSM SHALL return to IDLE.
REQ-024 BUSY SHALL therefore be high for exactly DEPTH cycles per clear.
REQ-025 In SWEEP, WRITE SHALL be ignored: no write, no bypass.
REQ-026 In SWEEP, a further CLEAR SHALL be ignored, with no restart and no extension.
REQ-027 In SWEEP, OUT1 and OUT2 SHALL load 0 every cycle.
REQ-028 The counter SHALL be AW bits wide, and its wrap from DEPTH-1 to 0 SHALL coincide with the return to IDLE.
REQ-029 The first IDLE cycle after a sweep SHALL accept WRITE and read normally, so all entries read 0 unless written.
REQ-030 Out-of-range addresses cannot occur, since DEPTH is a power of two; no address checking is required.

Reset
REQ-031 RESET=0 SHALL immediately, without waiting for CLK, clear every register to 0.
REQ-032 RESET=0 SHALL immediately clear OUT1=0, OUT2=0, BUSY=0, counter=0 and state=IDLE.
REQ-033 Reset asserted mid-sweep SHALL abort the sweep; after RESET=1, the FSM SHALL be in IDLE with all entries 0.
REQ-034 While RESET=0, WRITE and CLEAR SHALL have no effect.
REQ-035 Release of RESET SHALL be sampled at the rising edge following deassertion; the first write SHALL take effect on that edge.

Verification (WIDTH=8, DEPTH=8)
REQ-036 Write and read: write 8'hA5 to addr 3, then read addr 3 on port 1 -> OUT1=8'hA5 one cycle after the read address is presented.
REQ-037 Bypass: WRITE=1, INADDRESS=5, IN=8'h3C, OUT1ADDRESS=5, OUT2ADDRESS=5 in the same cycle -> OUT1=OUT2=8'h3C after that edge.
REQ-038 Clear: fill all 8 entries with 8'hFF, pulse CLEAR -> BUSY high for exactly 8 cycles, WRITE of 8'h11 during BUSY is dropped, then all addresses read 8'h00.
REQ-039 Clear/write collision: CLEAR=1 and WRITE=1 to addr 2 with 8'h77 in the same IDLE cycle -> addr 2 reads 8'h00 after the sweep.
REQ-040 Reset mid-sweep: pulse RESET low at sweep cycle 3 -> BUSY, OUT1 and OUT2 fall without a clock edge, and all entries read 0 after release.
REQ-041 ZERO_REG=1: write 8'h9E to addr 0 with bypass read of addr 0 -> OUT1=8'h00 on that cycle and all later reads.
